// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard / stall / halt controller for a 5-stage core
//
// Sequences the pipeline register enables and flushes from the hazard
// sources: data-memory freeze, taken branch, RAW hazard (no forwarding),
// instruction-fetch stall and HALT drain.
//
// Ports
//   clk              system clock
//   rst              synchronous active-high reset
//   IdRs, IdRt       ID-stage source registers
//   IdSrcUsed        [1] IdRs is read, [0] IdRt is read
//   IdHalt           ID holds a HALT instruction
//   ExWriteRegAddr   EX destination register
//   ExRegWrite       EX writes the register file
//   MemWriteRegAddr  MEM destination register
//   MemRegWrite      MEM writes the register file
//   MemMemEnable     MEM accesses data memory
//   DMemDone         data memory access completes this cycle
//   IMemStall        instruction fetch not yet valid
//   BranchTaken      EX resolved a taken branch/jump
//   PcWrEn           PC load enable
//   IfIdWrEn         IF/ID load enable
//   IfIdFlush        load a NOP into IF/ID
//   IdExWrEn         ID/EX load enable
//   IdExFlush        load a bubble into ID/EX
//   BackWrEn         EX/MEM and MEM/WB load enable
//   Halted           pipeline fully drained after HALT
//   StallCycles      (PIPE_CTRL_PERF_EN only) saturating count of cycles
//                    with PcWrEn=0 outside HALTED
//
// Build option: define PIPE_CTRL_PERF_EN to add the StallCycles counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RUN        | normal operation, hazard priority freeze>branch>RAW>IF
// MEM_WAIT   | pipeline frozen waiting on data memory
// HALT_DRAIN | HALT is in the back end; draining remaining instructions
// HALTED     | fully drained, everything held until reset
// ---------------------------------------------------------------------------
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  IdRs,
    input  logic [2:0]  IdRt,
    input  logic [1:0]  IdSrcUsed,
    input  logic        IdHalt,
    input  logic [2:0]  ExWriteRegAddr,
    input  logic        ExRegWrite,
    input  logic [2:0]  MemWriteRegAddr,
    input  logic        MemRegWrite,
    input  logic        MemMemEnable,
    input  logic        DMemDone,
    input  logic        IMemStall,
    input  logic        BranchTaken,
    output logic        PcWrEn,
    output logic        IfIdWrEn,
    output logic        IfIdFlush,
    output logic        IdExWrEn,
    output logic        IdExFlush,
    output logic        BackWrEn,
`ifdef PIPE_CTRL_PERF_EN
    output logic [15:0] StallCycles,
`endif
    output logic        Halted
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] drain_cnt, drain_cnt_nxt;
    logic       halt_pend, halt_pend_nxt;

    logic freeze;
    logic raw_rs, raw_rt, raw;
    logic run_mode, drain_mode;

    // Freeze comes from a new memory access that has not completed, or from
    // an access already being waited on.
    assign freeze = (MemMemEnable && !DMemDone) ||
                    ((state == MEM_WAIT) && !DMemDone);

    assign raw_rs = IdSrcUsed[1] &&
                    ((ExRegWrite  && (IdRs == ExWriteRegAddr)) ||
                     (MemRegWrite && (IdRs == MemWriteRegAddr)));
    assign raw_rt = IdSrcUsed[0] &&
                    ((ExRegWrite  && (IdRt == ExWriteRegAddr)) ||
                     (MemRegWrite && (IdRt == MemWriteRegAddr)));
    assign raw    = raw_rs || raw_rt;

    // The cycle in which MEM_WAIT sees DMemDone behaves like the state it
    // was frozen out of: RUN, or HALT_DRAIN when a halt is pending.
    assign run_mode   = (state == RUN)        || ((state == MEM_WAIT) && !halt_pend);
    assign drain_mode = (state == HALT_DRAIN) || ((state == MEM_WAIT) &&  halt_pend);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            halt_pend <= halt_pend_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        halt_pend_nxt = halt_pend;
        if (run_mode) begin
            if (freeze) begin
                state_nxt = MEM_WAIT;
            end else if (!BranchTaken && !raw && IdHalt) begin
                state_nxt     = HALT_DRAIN;
                drain_cnt_nxt = 2'd3;
                halt_pend_nxt = 1'b0;
            end else begin
                state_nxt     = RUN;
                halt_pend_nxt = 1'b0;
            end
        end else if (drain_mode) begin
            if (freeze) begin
                // count is held across the freeze
                state_nxt     = MEM_WAIT;
                halt_pend_nxt = 1'b1;
            end else if ((state == HALT_DRAIN) && (drain_cnt == 2'd0)) begin
                state_nxt = HALTED;
            end else begin
                state_nxt     = HALT_DRAIN;
                halt_pend_nxt = 1'b0;
                if (drain_cnt != 2'd0) begin
                    drain_cnt_nxt = drain_cnt - 2'd1;
                end
            end
        end else begin
            state_nxt = HALTED;
        end
    end

    // output logic
    always_comb begin
        PcWrEn    = 1'b0;
        IfIdWrEn  = 1'b0;
        IfIdFlush = 1'b0;
        IdExWrEn  = 1'b0;
        IdExFlush = 1'b0;
        BackWrEn  = 1'b0;
        Halted    = 1'b0;
        if (rst) begin
            IfIdFlush = 1'b1;
            IdExFlush = 1'b1;
        end else if (state == HALTED) begin
            Halted = 1'b1;
        end else if (freeze) begin
            // everything held, nothing flushed
        end else if (drain_mode) begin
            IfIdWrEn  = 1'b1;
            IfIdFlush = 1'b1;
            IdExWrEn  = 1'b1;
            IdExFlush = 1'b1;
            BackWrEn  = 1'b1;
        end else if (BranchTaken) begin
            // a pending fetch is simply abandoned by the redirect
            PcWrEn    = 1'b1;
            IfIdWrEn  = 1'b1;
            IfIdFlush = 1'b1;
            IdExWrEn  = 1'b1;
            IdExFlush = 1'b1;
            BackWrEn  = 1'b1;
        end else if (raw) begin
            IdExWrEn  = 1'b1;
            IdExFlush = 1'b1;
            BackWrEn  = 1'b1;
        end else if (IdHalt) begin
            // HALT moves into EX; nothing behind it is fetched
            IfIdWrEn  = 1'b1;
            IfIdFlush = 1'b1;
            IdExWrEn  = 1'b1;
            BackWrEn  = 1'b1;
        end else if (IMemStall) begin
            IfIdWrEn  = 1'b1;
            IfIdFlush = 1'b1;
            IdExWrEn  = 1'b1;
            BackWrEn  = 1'b1;
        end else begin
            PcWrEn    = 1'b1;
            IfIdWrEn  = 1'b1;
            IdExWrEn  = 1'b1;
            BackWrEn  = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCycles <= 16'd0;
        end else if ((state != HALTED) && !PcWrEn && (StallCycles != 16'hFFFF)) begin
            StallCycles <= StallCycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  IdRs, IdRt, ExWriteRegAddr, MemWriteRegAddr;
    logic [1:0]  IdSrcUsed;
    logic        IdHalt, ExRegWrite, MemRegWrite, MemMemEnable, DMemDone;
    logic        IMemStall, BranchTaken;
    logic        PcWrEn, IfIdWrEn, IfIdFlush, IdExWrEn, IdExFlush, BackWrEn, Halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] StallCycles;
`endif

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .IdRs            (IdRs),
        .IdRt            (IdRt),
        .IdSrcUsed       (IdSrcUsed),
        .IdHalt          (IdHalt),
        .ExWriteRegAddr  (ExWriteRegAddr),
        .ExRegWrite      (ExRegWrite),
        .MemWriteRegAddr (MemWriteRegAddr),
        .MemRegWrite     (MemRegWrite),
        .MemMemEnable    (MemMemEnable),
        .DMemDone        (DMemDone),
        .IMemStall       (IMemStall),
        .BranchTaken     (BranchTaken),
        .PcWrEn          (PcWrEn),
        .IfIdWrEn        (IfIdWrEn),
        .IfIdFlush       (IfIdFlush),
        .IdExWrEn        (IdExWrEn),
        .IdExFlush       (IdExFlush),
        .BackWrEn        (BackWrEn),
`ifdef PIPE_CTRL_PERF_EN
        .StallCycles     (StallCycles),
`endif
        .Halted          (Halted)
    );

    // {PcWrEn, IfIdWrEn, IfIdFlush, IdExWrEn, IdExFlush, BackWrEn, Halted}
    localparam logic [6:0] V_NORM = 7'b1101010, M_ALL  = 7'b1111111;
    localparam logic [6:0] V_FRZ  = 7'b0000000;
    localparam logic [6:0] V_RST  = 7'b0010100;
    localparam logic [6:0] V_RAW  = 7'b0001110, M_RAW  = 7'b1100111;
    localparam logic [6:0] V_BR   = 7'b1111110, M_BR   = 7'b1010111;
    localparam logic [6:0] V_IMS  = 7'b0011010, M_IMS  = 7'b1011111;
    localparam logic [6:0] V_HADV = 7'b0001010, M_HADV = 7'b0001111;
    localparam logic [6:0] V_DRN  = 7'b0010100, M_DRN  = 7'b1010101;
    localparam logic [6:0] V_HLT  = 7'b0000001, M_HLT  = 7'b1101011;

    typedef struct {
        string      tag;
        logic [6:0] exp;
        logic [6:0] mask;
    } sb_item_t;

    sb_item_t sb[$];
    int n_chk  = 0;
    int n_pass = 0;

    wire [6:0] obs_v = {PcWrEn, IfIdWrEn, IfIdFlush, IdExWrEn, IdExFlush, BackWrEn, Halted};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle();
        rst = 1'b0; IdRs = 3'd0; IdRt = 3'd0; IdSrcUsed = 2'b00; IdHalt = 1'b0;
        ExWriteRegAddr = 3'd0; ExRegWrite = 1'b0;
        MemWriteRegAddr = 3'd0; MemRegWrite = 1'b0;
        MemMemEnable = 1'b0; DMemDone = 1'b0; IMemStall = 1'b0; BranchTaken = 1'b0;
    endtask

    // inputs already driven; push expectation, compare at negedge, advance
    task automatic step(input string tag, input logic [6:0] exp, input logic [6:0] mask);
        sb_item_t it, got;
        it.tag = tag; it.exp = exp; it.mask = mask;
        sb.push_back(it);
        @(negedge clk);
        got = sb.pop_front();
        check(got.tag, {25'd0, obs_v & got.mask}, {25'd0, got.exp & got.mask});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        step("reset", V_RST, M_ALL);
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step("reset0", V_RST, M_ALL);
        step("reset1", V_RST, M_ALL);
        idle();
        step("run_idle", V_NORM, M_ALL);

        // RAW via EX, then via MEM, then clear
        IdRs = 3'd3; IdSrcUsed = 2'b10; ExWriteRegAddr = 3'd3; ExRegWrite = 1'b1;
        step("raw_ex", V_RAW, M_RAW);
        ExWriteRegAddr = 3'd5; MemWriteRegAddr = 3'd3; MemRegWrite = 1'b1;
        step("raw_mem", V_RAW, M_RAW);
        MemRegWrite = 1'b0;
        step("raw_clear", V_NORM, M_ALL);
        // Rt hazard only when IdRt is marked used
        idle(); IdRt = 3'd6; IdSrcUsed = 2'b01; MemWriteRegAddr = 3'd6; MemRegWrite = 1'b1;
        step("raw_rt", V_RAW, M_RAW);
        IdSrcUsed = 2'b10;
        step("rt_unused", V_NORM, M_ALL);
        idle(); IdRs = 3'd4; IdSrcUsed = 2'b10; ExWriteRegAddr = 3'd4; ExRegWrite = 1'b0;
        step("ex_nowrite", V_NORM, M_ALL);

        // IF stall
        idle(); IMemStall = 1'b1;
        step("imem_stall", V_IMS, M_IMS);

        // branch overrides RAW and IF stall
        idle(); BranchTaken = 1'b1; IMemStall = 1'b1;
        IdRs = 3'd2; IdSrcUsed = 2'b10; ExWriteRegAddr = 3'd2; ExRegWrite = 1'b1;
        step("branch", V_BR, M_BR);

        // data memory freeze: 4 frozen cycles, then done
        idle(); MemMemEnable = 1'b1;
        for (int i = 0; i < 4; i++) step("freeze", V_FRZ, M_ALL);
        DMemDone = 1'b1;
        step("freeze_done", V_NORM, M_ALL);
        idle();
        step("after_freeze", V_NORM, M_ALL);

        // freeze beats branch
        MemMemEnable = 1'b1; BranchTaken = 1'b1;
        step("freeze_vs_br", V_FRZ, M_ALL);
        idle(); MemMemEnable = 1'b1; DMemDone = 1'b1;
        step("freeze_vs_br_done", V_NORM, M_ALL);

        // HALT: 4 drain cycles then HALTED until reset
        idle(); IdHalt = 1'b1;
        step("halt_adv", V_HADV, M_HADV);
        idle();
        for (int i = 0; i < 4; i++) step("drain", V_DRN, M_DRN);
        for (int i = 0; i < 3; i++) step("halted", V_HLT, M_HLT);
        IdHalt = 1'b1; BranchTaken = 1'b1;
        step("halted_sticky", V_HLT, M_HLT);
        do_reset();
        step("run_after_halt", V_NORM, M_ALL);

        // HALT with a 2-cycle freeze mid-drain: Halted two cycles later
        IdHalt = 1'b1;
        step("halt2_adv", V_HADV, M_HADV);
        idle();
        step("drain2", V_DRN, M_DRN);
        MemMemEnable = 1'b1;
        step("drain_frz", V_FRZ, M_ALL);
        step("drain_frz", V_FRZ, M_ALL);
        DMemDone = 1'b1;
        step("drain_done", V_DRN, M_DRN);
        idle();
        step("drain2", V_DRN, M_DRN);
        step("drain2", V_DRN, M_DRN);
        step("halted2", V_HLT, M_HLT);
        do_reset();
        step("run_after_halt2", V_NORM, M_ALL);

        // reset mid-freeze and mid-drain abandons the operation
        MemMemEnable = 1'b1;
        step("pre_rst_frz", V_FRZ, M_ALL);
        do_reset();
        step("rst_mid_freeze", V_NORM, M_ALL);
        IdHalt = 1'b1;
        step("halt3_adv", V_HADV, M_HADV);
        idle();
        step("drain3", V_DRN, M_DRN);
        do_reset();
        step("rst_mid_drain", V_NORM, M_ALL);

`ifdef PIPE_CTRL_PERF_EN
        do_reset();
        IdRs = 3'd1; IdSrcUsed = 2'b10; ExWriteRegAddr = 3'd1; ExRegWrite = 1'b1;
        for (int i = 0; i < 5; i++) step("perf_raw", V_RAW, M_RAW);
        idle(); MemMemEnable = 1'b1;
        for (int i = 0; i < 3; i++) step("perf_frz", V_FRZ, M_ALL);
        DMemDone = 1'b1;
        step("perf_done", V_NORM, M_ALL);
        idle();
        @(negedge clk);
        check("stall_cnt8", {16'd0, StallCycles}, 32'd8);
        @(posedge clk); #1;
        IMemStall = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_sat", {16'd0, StallCycles}, 32'h0000FFFF);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_sat_hold", {16'd0, StallCycles}, 32'h0000FFFF);
        idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock, clk, and reset rst, which is synchronous and active-high; all state updates occur on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 IdRs  input  3  source register A of the instruction in ID.
REQ-005 IdRt  input  3  source register B of the instruction in ID.
REQ-006 IdSrcUsed  input  2  bit1 = IdRs read, bit0 = IdRt read.
REQ-007 IdHalt  input  1  ID holds a HALT instruction.
REQ-008 ExWriteRegAddr  input  3  destination register of the instruction in EX.
REQ-009 ExRegWrite  input  1  EX instruction writes the register file.
REQ-010 MemWriteRegAddr  input  3  destination register of the instruction in MEM.
REQ-011 MemRegWrite  input  1  MEM instruction writes the register file.
REQ-012 MemMemEnable  input  1  MEM instruction accesses data memory.
REQ-013 DMemDone  input  1  data memory access complete this cycle.
REQ-014 IMemStall  input  1  instruction fetch not yet valid.
REQ-015 BranchTaken  input  1  EX resolved a taken branch or jump.
REQ-016 PcWrEn  output  1  PC load enable.
REQ-017 IfIdWrEn  output  1  IF/ID register load enable.
REQ-018 IfIdFlush  output  1  load a NOP into IF/ID.
REQ-019 IdExWrEn  output  1  ID/EX register load enable.
REQ-020 IdExFlush  output  1  load zeroed control (bubble) into ID/EX.
REQ-021 BackWrEn  output  1  EX/MEM and MEM/WB load enable.
REQ-022 Halted  output  1  processor fully drained after HALT.

Function
REQ-023 The FSM SHALL have four states: RUN, MEM_WAIT, HALT_DRAIN and HALTED.
REQ-024 A RAW hazard SHALL exist when a used ID source equals ExWriteRegAddr with ExRegWrite=1, or equals MemWriteRegAddr with MemRegWrite=1; there is no forwarding.
REQ-025 A freeze SHALL exist when MemMemEnable=1 and DMemDone=0, or when the state is MEM_WAIT and DMemDone=0.
REQ-026 In RUN, a freeze SHALL move the FSM to MEM_WAIT; in MEM_WAIT, DMemDone=1 SHALL return it to RUN, or to HALT_DRAIN if a halt is pending.
REQ-027 During a freeze, every WrEn output SHALL be 0 and every Flush output SHALL be 0; freeze has the highest priority.
REQ-028 With no freeze and BranchTaken=1, the outputs SHALL be PcWrEn=1, IfIdFlush=1, IdExFlush=1 and BackWrEn=1; this overrides RAW hazards and IMemStall, which is abortable.
REQ-029 With no freeze or branch and a RAW hazard, the outputs SHALL be PcWrEn=IfIdWrEn=0, IdExFlush=1 and BackWrEn=1.
REQ-030 With no freeze, branch or RAW hazard, and IMemStall=1, the outputs SHALL be PcWrEn=0 and IfIdFlush=1, with ID/EX and the back stages advancing.
REQ-031 When IdHalt=1 in RUN with no freeze, branch or RAW hazard, the halt SHALL advance into EX, the FSM SHALL enter HALT_DRAIN, and the drain counter SHALL be loaded with 3.
REQ-032 In HALT_DRAIN, PcWrEn SHALL be 0, IfIdFlush SHALL be 1 and IdExFlush SHALL be 1.
REQ-033 In HALT_DRAIN, the drain counter SHALL decrement on each non-frozen cycle, and a count of 0 with no freeze SHALL move the FSM to HALTED.
REQ-034 In HALTED, all WrEn outputs SHALL be 0 and Halted SHALL be 1; only rst exits HALTED.
REQ-035 A freeze arriving during HALT_DRAIN SHALL enter MEM_WAIT with the drain count held and a halt-pending flag set.

Reset
REQ-036 While rst=1, all WrEn outputs SHALL be 0, IfIdFlush and IdExFlush SHALL be 1, and Halted SHALL be 0; the state SHALL become RUN with the drain counter and pending flag at 0.
REQ-037 Reset mid-freeze or mid-drain SHALL abandon that operation, and the first cycle after reset SHALL be RUN.

Configuration
REQ-038 With PIPE_CTRL_PERF_EN defined, a 16-bit output StallCycles SHALL count cycles with PcWrEn=0 outside HALTED, saturating at 0xFFFF and reset to 0; without the macro, neither the port nor the counter SHALL exist.

Verification
REQ-039 Scenario: IdRs=3, IdSrcUsed=2'b10, ExWriteRegAddr=3, ExRegWrite=1 -> PcWrEn=0, IdExFlush=1, BackWrEn=1; on the next cycle, with the EX stage holding reg 5, the hazard is still flagged via the MEM stage, and the following cycle PcWrEn=1.
REQ-040 Scenario: MemMemEnable=1 with DMemDone=0 for 4 cycles -> MEM_WAIT, all WrEn=0 for 4 cycles, then RUN with all WrEn=1 in the DMemDone cycle.
REQ-041 Scenario: BranchTaken=1 together with a RAW hazard and IMemStall=1 -> PcWrEn=1, IfIdFlush=1, IdExFlush=1.
REQ-042 Scenario: IdHalt=1 in RUN -> HALT_DRAIN for 4 cycles, then Halted=1, and Halted stays 1 until rst.
REQ-043 Scenario: a freeze of 2 cycles during HALT_DRAIN -> Halted asserts 2 cycles later than without the freeze; rst asserted in HALTED -> Halted=0 and state RUN next cycle.
REQ-044 Scenario (PIPE_CTRL_PERF_EN): 5 RAW-stall cycles plus 3 freeze cycles -> StallCycles=8; forcing 0xFFFF and stalling once more -> StallCycles remains 0xFFFF.
